jt900h_simmon: RTL and testbench
================================

# jt900h_simmon

Parametrised run/stop monitor and register-dump sequencer for jt900h CPU bring-up. Sits between the system clock domain and the CPU core:
- generates the CPU clock enable;
- watches the CPU RAM write bus for the stop write, a cycle-count timeout or an external request;
- on any of these, freezes the core and walks its debug dump port into an internal byte buffer;
- streams a cause header plus the captured bytes out on a valid/ready byte interface.

It generalises the fixed 84-byte dump and free-running/half-rate enable into a configurable, re-armable, synthesizable block.

## Interface

Parameters:
- AW, 24: CPU RAM address width.
- STOP_ADDR, 24'hffff: address whose upper-byte write (we[1]) requests a stop; compared on all AW bits.
- DUMPLEN, 84: bytes read from the dump port (1..256).
- TIMEOUT, 100000: RUN cycles before forced stop; 0 disables the timeout.
- CENHALF, 0: 0 = cpu_cen high every cycle in RUN; 1 = cpu_cen toggles every cycle in RUN.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset; asynchronous, active-high.
- ram_addr, in, AW: CPU RAM address.
- ram_we, in, 2: CPU byte write enables.
- ext_stop, in, 1: external stop request, level, sampled in RUN.
- clr, in, 1: re-arm pulse, honoured only in DONE.
- cpu_cen, out, 1: CPU clock enable.
- dmp_addr, out, 8: dump-port address.
- dmp_din, in, 8: dump-port data for the dmp_addr presented in the previous cycle.
- out_data, out, 8: stream byte.
- out_valid, out, 1: stream valid.
- out_ready, in, 1: stream ready.
- out_last, out, 1: marks the final stream byte.
- cause, out, 2: stop cause. 0 none, 1 stop write, 2 timeout, 3 external.
- done, out, 1: high in DONE.

## Operation

- States: RUN → DUMP → SEND → DONE → (clr) RUN.
- Reset values:
  - state RUN; cpu_cen=1; dmp_addr=0.
  - out_valid=0, out_last=0, out_data=0.
  - cause=0, done=0; timeout counter 0.
- RUN:
  - cpu_cen=1 (CENHALF=0), or inverts every clk starting from 1 (CENHALF=1).
  - Timeout counter increments every clk.
- Trigger, evaluated in RUN only, with priority:
  1. stop: ram_we[1]=1 and ram_addr==STOP_ADDR, regardless of cpu_cen.
  2. timeout: counter==TIMEOUT-1, with TIMEOUT≠0.
  3. external: ext_stop=1.
  - Trigger latches cause and moves to DUMP.
- DUMP:
  - cpu_cen=0.
  - dmp_addr counts 0..DUMPLEN-1, one step per clk, then holds.
  - Capture: buf[dmp_addr_prev] ← dmp_din, one cycle after each address. The last capture lands the cycle after dmp_addr=DUMPLEN-1.
  - Then go to SEND.
- SEND:
  - Byte 0 = {6'd0,cause}; bytes 1..DUMPLEN = buf[0..DUMPLEN-1].
  - out_last is high with byte DUMPLEN.
  - AXI-style handshake: a byte is transferred when out_valid&out_ready. out_data/out_last are stable while out_valid=1 and out_ready=0. out_valid never drops before a transfer.
  - After the last transfer go to DONE; out_valid=0.
- DONE:
  - done=1; cpu_cen=0.
  - clr=1 → RUN. Counter, cause, dmp_addr and done are cleared. The buffer is not cleared.
- Simultaneous stop write and timeout expiry: cause=1.
- ram_we/ext_stop outside RUN are ignored.
- clr outside DONE is ignored.
- Async rst at any point returns to RUN at once, with the reset values above.

## Timing

- Trigger seen in cycle T:
  - state=DUMP and cpu_cen=0 from T+1.
  - dmp_addr=0 at T+1 and DUMPLEN-1 at T+DUMPLEN.
  - Final capture at edge T+DUMPLEN+1; state=SEND and out_valid=1 from T+DUMPLEN+1.
- With out_ready held high, SEND lasts DUMPLEN+1 cycles; DONE follows the cycle after the out_last transfer.
- clr in cycle C: RUN from C+1; cpu_cen=1 at C+1.
- Timeout with ready held high: first stop at RUN cycle TIMEOUT-1, counting the first post-reset cycle as 0.
- Counter width is $clog2(TIMEOUT+1). No wrap occurs because the trigger precedes overflow.

## Structure

- Shared package jt900h_simmon_pkg holds:
  - cause encodings CAUSE_NONE/STOP/TOUT/EXT;
  - state encodings ST_RUN/ST_DUMP/ST_SEND/ST_DONE.
- One sub-module, jt900h_dmpbuf: DUMPLEN×8 register file with one registered write port and one combinational read port, indexed by an 8-bit address.
- The FSM, cen generator, timeout counter and stream pointer live in jt900h_simmon.

## Test plan

- Stop write (DUMPLEN=84, dmp_din=~dmp_addr, ready=1): write we=2'b10 to 24'h00ffff at T → cpu_cen=0 at T+1; stream 85 bytes: 8'h01, 8'hff, 8'hfe, …, 8'hac; out_last on byte 85; then done=1.
- Non-stop writes: we=2'b01 to 24'h00ffff, or we=2'b10 to 24'h01ffff → no trigger; cpu_cen stays 1.
- Timeout (TIMEOUT=50, no stop) → cause=2; cpu_cen low from RUN cycle 50; header byte 8'h02.
- Backpressure: out_ready toggling 1/0 with a 3-cycle low burst → every byte is delivered once, in order; data is stable while stalled; byte count is 85.
- Collision: stop write in the same cycle as timeout expiry with ext_stop=1 → cause=1. Then clr → RUN; cpu_cen toggles 1,0,1 under CENHALF=1; the counter restarts from 0.
- Async rst asserted mid-SEND after 10 bytes → immediate out_valid=0, cpu_cen=1, dmp_addr=0, cause=0; the next trigger produces a full 85-byte stream.

Source files
------------

// File: rtl/jt900h_simmon_pkg.sv
// rtl/jt900h_simmon_pkg.sv - shared encodings for the jt900h run/stop monitor
package jt900h_simmon_pkg;

   // Why the core was frozen; the value is also the stream header byte
   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_STOP = 2'd1,
      CAUSE_TOUT = 2'd2,
      CAUSE_EXT  = 2'd3
   } cause_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DUMP = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/jt900h_dmpbuf.sv
// rtl/jt900h_dmpbuf.sv - dump byte buffer, one registered write port, one combinational read port
module jt900h_dmpbuf #(
   parameter int DUMPLEN = 84
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   localparam int IW = (DUMPLEN > 1) ? $clog2(DUMPLEN) : 1;

   logic [7:0] mem [DUMPLEN];

   logic w_in, r_in;
   assign w_in = 9'(waddr) < 9'(DUMPLEN);
   assign r_in = 9'(raddr) < 9'(DUMPLEN);

   // Capture dump bytes; contents deliberately survive reset and re-arm
   always_ff @(posedge clk) begin
      if (we && w_in) mem[waddr[IW-1:0]] <= wdata;
   end

   assign rdata = r_in ? mem[raddr[IW-1:0]] : 8'd0;

endmodule

// File: rtl/jt900h_simmon.sv
// rtl/jt900h_simmon.sv - jt900h run/stop monitor with register-dump byte stream
module jt900h_simmon
   import jt900h_simmon_pkg::*;
#(
   parameter int            AW        = 24,
   parameter logic [AW-1:0] STOP_ADDR = AW'(24'hffff),
   parameter int            DUMPLEN   = 84,
   parameter int            TIMEOUT   = 100000,
   parameter bit            CENHALF   = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ram_addr,
   input  logic [1:0]    ram_we,
   input  logic          ext_stop,
   input  logic          clr,
   output logic          cpu_cen,
   output logic [7:0]    dmp_addr,
   input  logic [7:0]    dmp_din,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [1:0]    cause,
   output logic          done
);

   localparam int             CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  TOUT_LAST = CW'(TIMEOUT - 1);
   localparam logic [7:0]     LAST_ADDR = 8'(DUMPLEN - 1);
   localparam logic [8:0]     NBYTES    = 9'(DUMPLEN);

   state_t        state;
   cause_t        cause_r;
   cause_t        trig_cause;
   logic          trig;
   logic [CW-1:0] cnt;
   logic          cap_vld;
   logic [7:0]    cap_addr;
   logic [8:0]    ptr;
   logic [7:0]    rd_addr;
   logic [7:0]    buf_q;
   logic [7:0]    rd_byte;

   assign cause = cause_r;

   // The dump port answers one cycle late, so each write lands on the address of the previous cycle
   jt900h_dmpbuf #(.DUMPLEN(DUMPLEN)) u_buf (
      .clk   (clk),
      .we    (cap_vld),
      .waddr (cap_addr),
      .wdata (dmp_din),
      .raddr (rd_addr),
      .rdata (buf_q)
   );

   // ptr is the stream index of the next byte to load; byte n comes from buffer entry n-1
   assign rd_addr = 8'(ptr - 9'd1);
   // Forward a capture still in flight (only reachable when DUMPLEN is tiny)
   assign rd_byte = (cap_vld && cap_addr == rd_addr) ? dmp_din : buf_q;

   // Stop-cause priority: stop write, then timeout expiry, then external request
   always_comb begin
      trig       = 1'b1;
      trig_cause = CAUSE_NONE;
      if (ram_we[1] && ram_addr == STOP_ADDR)
         trig_cause = CAUSE_STOP;
      else if (TIMEOUT != 0 && cnt == TOUT_LAST)
         trig_cause = CAUSE_TOUT;
      else if (ext_stop)
         trig_cause = CAUSE_EXT;
      else
         trig = 1'b0;
   end

   // Run/dump/send/done sequencer with clock enable, timeout counter and stream pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         cpu_cen   <= 1'b1;
         dmp_addr  <= 8'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= 8'd0;
         cause_r   <= CAUSE_NONE;
         done      <= 1'b0;
         cnt       <= '0;
         cap_vld   <= 1'b0;
         cap_addr  <= 8'd0;
         ptr       <= 9'd0;
      end else begin
         cap_vld  <= (state == ST_DUMP);
         cap_addr <= dmp_addr;
         case (state)
            ST_RUN: begin
               if (TIMEOUT != 0) cnt <= cnt + 1'b1;
               cpu_cen <= CENHALF ? ~cpu_cen : 1'b1;
               if (trig) begin
                  state    <= ST_DUMP;
                  cause_r  <= trig_cause;
                  cpu_cen  <= 1'b0;
                  dmp_addr <= 8'd0;
               end
            end
            ST_DUMP: begin
               if (dmp_addr == LAST_ADDR) begin
                  state     <= ST_SEND;
                  out_valid <= 1'b1;
                  out_data  <= {6'd0, cause_r};
                  out_last  <= 1'b0;
                  ptr       <= 9'd1;
               end else begin
                  dmp_addr <= dmp_addr + 8'd1;
               end
            end
            ST_SEND: begin
               if (out_valid && out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     out_data <= rd_byte;
                     out_last <= (ptr == NBYTES);
                     ptr      <= ptr + 9'd1;
                  end
               end
            end
            ST_DONE: begin
               if (clr) begin
                  state    <= ST_RUN;
                  cpu_cen  <= 1'b1;
                  cnt      <= '0;
                  cause_r  <= CAUSE_NONE;
                  dmp_addr <= 8'd0;
                  done     <= 1'b0;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_jt900h_simmon.sv
// tb/tb_jt900h_simmon.sv - self-checking bench for jt900h_simmon
module tb_jt900h_simmon;

   localparam int DL = 84;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] ram_addr = 24'd0;
   logic [1:0]  ram_we = 2'b00;
   logic        ext_stop = 1'b0;
   logic        clr = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  dmp_din = 8'd0;
   logic        cpu_cen;
   logic [7:0]  dmp_addr;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  cause;
   logic        done;

   int checks = 0;
   int failures = 0;
   int k, t, nb, nc;

   jt900h_simmon #(
      .AW(24), .STOP_ADDR(24'h00ffff), .DUMPLEN(DL), .TIMEOUT(50), .CENHALF(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_we(ram_we), .ext_stop(ext_stop),
      .clr(clr), .cpu_cen(cpu_cen), .dmp_addr(dmp_addr), .dmp_din(dmp_din),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .cause(cause), .done(done)
   );

   always #5 clk = ~clk;

   // Core dump port model: one cycle of latency, byte value is the inverted address
   always @(posedge clk) dmp_din <= ~dmp_addr;

   initial begin
      #100000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // In RUN with half-rate enable, cpu_cen is 1 on even run cycles and 0 on odd ones
   task automatic run_to(inout int kk, input int target);
      while (kk < target) begin
         @(negedge clk);
         kk++;
         check("cen_run", cpu_cen, (kk % 2 == 0));
      end
   endtask

   // Receive the stream and compare against header + inverted-address dump bytes
   task automatic collect(input int mode, input int stop_after, input logic [1:0] ec,
                          output int nbytes, output int ncyc);
      logic       stall, sl, fin;
      logic [7:0] sd, e;
      stall = 0; sl = 0; fin = 0; sd = 0; nbytes = 0; ncyc = 0;
      while (!fin) begin
         if (mode == 0) out_ready = 1'b1;
         else out_ready = (ncyc >= 3 && ncyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
         if (stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, sd);
            check("stall_last", out_last, sl);
         end
         if (out_valid && out_ready) begin
            e = (nbytes == 0) ? {6'd0, ec} : ~8'(nbytes - 1);
            check("byte", out_data, e);
            check("last", out_last, (nbytes == DL));
            nbytes++;
            stall = 0;
            if (out_last || nbytes == stop_after) fin = 1;
         end else begin
            stall = out_valid; sd = out_data; sl = out_last;
         end
         ncyc++;
         if (!fin && ncyc > 1000) begin
            checks++; failures++;
            $error("FAIL stream_timeout observed=%0d expected=%0d", nbytes, DL + 1);
            fin = 1;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cen", cpu_cen, 1);
      check("rst_dmp_addr", dmp_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_cause", cause, 0);
      check("rst_done", done, 0);
      rst = 1'b0; k = 0;

      // Writes that must not trigger
      @(negedge clk); k++; check("cen_run", cpu_cen, 0);
      ram_addr = 24'h00ffff; ram_we = 2'b01;
      @(negedge clk); k++; check("nostop_lo_cen", cpu_cen, 1); check("nostop_lo_cause", cause, 0);
      ram_addr = 24'h01ffff; ram_we = 2'b10;
      @(negedge clk); k++; check("nostop_addr_cen", cpu_cen, 0); check("nostop_addr_cause", cause, 0);
      ram_addr = 24'd0; ram_we = 2'b00;
      @(negedge clk); k++; check("nostop_cen", cpu_cen, 1); check("nostop_cause", cause, 0);

      // Stop write at a random run cycle; clr and ext_stop during DUMP are ignored
      t = 4 + $urandom_range(0, 8);
      run_to(k, t);
      ram_addr = 24'h00ffff; ram_we = 2'b10;
      @(negedge clk);
      check("stop_cen", cpu_cen, 0); check("stop_cause", cause, 1); check("stop_addr0", dmp_addr, 0);
      ram_we = 2'b00; ext_stop = 1'b1; clr = 1'b1;
      @(negedge clk);
      ext_stop = 1'b0; clr = 1'b0;
      check("dump_addr1", dmp_addr, 1);
      repeat (82) @(negedge clk);
      check("dump_addr_last", dmp_addr, DL - 1); check("dump_valid", out_valid, 0);
      @(negedge clk);
      check("send_valid", out_valid, 1); check("send_cause", cause, 1);
      collect(0, 0, 2'd1, nb, nc);
      check("stop_nbytes", nb, DL + 1); check("stop_ncyc", nc, DL + 1);
      check("stop_done", done, 1); check("done_valid", out_valid, 0); check("done_cen", cpu_cen, 0);

      // Re-arm, then timeout with random backpressure
      clr = 1'b1;
      @(negedge clk); clr = 1'b0; k = 0;
      check("clr_cen", cpu_cen, 1); check("clr_done", done, 0);
      check("clr_cause", cause, 0); check("clr_dmp_addr", dmp_addr, 0);
      run_to(k, 49);
      @(negedge clk); k++;
      check("tout_cen", cpu_cen, 0); check("tout_cause", cause, 2);
      repeat (84) @(negedge clk);
      check("tout_valid", out_valid, 1);
      collect(1, 0, 2'd2, nb, nc);
      check("tout_nbytes", nb, DL + 1); check("tout_done", done, 1);

      // Re-arm, then stop write + timeout + external in the same cycle
      clr = 1'b1;
      @(negedge clk); clr = 1'b0; k = 0;
      check("clr2_cen", cpu_cen, 1);
      run_to(k, 49);
      ram_addr = 24'h00ffff; ram_we = 2'b10; ext_stop = 1'b1;
      @(negedge clk);
      check("coll_cause", cause, 1); check("coll_cen", cpu_cen, 0);
      ram_we = 2'b00; ext_stop = 1'b0;
      repeat (84) @(negedge clk);
      check("coll_valid", out_valid, 1);
      ext_stop = 1'b1; ram_we = 2'b10;
      collect(0, 10, 2'd1, nb, nc);
      check("coll_nbytes", nb, 10); check("coll_cause_kept", cause, 1);
      ext_stop = 1'b0; ram_we = 2'b00;

      // Asynchronous reset in the middle of SEND
      #2 rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0); check("arst_cen", cpu_cen, 1);
      check("arst_dmp_addr", dmp_addr, 0); check("arst_cause", cause, 0);
      check("arst_done", done, 0); check("arst_last", out_last, 0);
      @(negedge clk); rst = 1'b0; k = 0;

      // External stop after reset, full stream under backpressure
      t = $urandom_range(2, 20);
      run_to(k, t);
      ext_stop = 1'b1;
      @(negedge clk);
      check("ext_cause", cause, 3); check("ext_cen", cpu_cen, 0);
      ext_stop = 1'b0;
      repeat (84) @(negedge clk);
      collect(1, 0, 2'd3, nb, nc);
      check("ext_nbytes", nb, DL + 1); check("ext_done", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
